// File: rtl/nf10_axi_lite_master_pkg.sv
// Shared definitions for the NF10 AXI4-Lite command master:
// FSM state encoding and AXI response codes.
package nf10_axi_lite_defs;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned TIMEOUT_CNT_W = 16;

endpackage

// File: rtl/nf10_axi_lite_master_timeout_counter.sv
// Response-wait counter: counts enabled cycles from zero and flags the cycle
// on which the count reaches LIMIT. LIMIT of 0 never expires.
module nf10_timeout_counter
  import nf10_axi_lite_defs::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMEOUT_CNT_W-1:0] LAST =
    (LIMIT == 0) ? '0 : TIMEOUT_CNT_W'(LIMIT - 1);

  logic [TIMEOUT_CNT_W-1:0] cnt_q;
  logic [TIMEOUT_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The count reaches LIMIT on the edge that ends the LIMIT-th enabled cycle.
  assign expired_o = (LIMIT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/nf10_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI read or
// write, with an optional response-wait timeout, and returns one response.
module nf10_axi_lite_master
  import nf10_axi_lite_defs::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,

  input  logic                            CMD_VALID,
  output logic                            CMD_READY,
  input  logic                            CMD_RNW,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,

  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]                      RSP_RESP,
  output logic                            RSP_TIMEOUT,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_t                          state_q;
  logic                            cmd_ready_q;
  logic                            awvalid_q;
  logic                            wvalid_q;
  logic                            arvalid_q;
  logic                            bready_q;
  logic                            rready_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]               wstrb_q;
  logic                            rsp_valid_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]                      rsp_resp_q;
  logic                            rsp_timeout_q;

  logic wait_en;
  logic expired;

  assign wait_en = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);

  nf10_timeout_counter #(
    .LIMIT (C_TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (S_AXI_ACLK),
    .rst_ni    (S_AXI_ARESETN),
    .en_i      (wait_en),
    .expired_o (expired)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready and B/R sinks come up one cycle after reset or DONE.
          if (CMD_VALID && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= CMD_ADDR;
            wdata_q     <= CMD_WDATA;
            wstrb_q     <= CMD_WSTRB;
            if (CMD_RNW) begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end else begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end
          end else begin
            cmd_ready_q <= 1'b1;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
          end
        end

        ST_WR_REQ: begin
          if (M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            rsp_resp_q    <= M_AXI_BRESP;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            bready_q      <= 1'b0;
            state_q       <= ST_DONE;
          end else if (expired) begin
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            bready_q      <= 1'b0;
            state_q       <= ST_DONE;
          end
        end

        ST_RD_REQ: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end

        ST_RD_RESP: begin
          if (M_AXI_RVALID) begin
            rsp_resp_q    <= M_AXI_RRESP;
            rsp_rdata_q   <= M_AXI_RDATA;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rready_q      <= 1'b0;
            state_q       <= ST_DONE;
          end else if (expired) begin
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            rready_q      <= 1'b0;
            state_q       <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            bready_q    <= 1'b1;
            rready_q    <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY     = cmd_ready_q;
  assign RSP_VALID     = rsp_valid_q;
  assign RSP_RDATA     = rsp_rdata_q;
  assign RSP_RESP      = rsp_resp_q;
  assign RSP_TIMEOUT   = rsp_timeout_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
